dibit_packer: RTL and testbench

- Downstream consumer of the 2-bit `{a,b}` concat stage.
- Collects a stream of 2-bit symbols (dibits) MSB-first and packs them into OUT_WIDTH-bit words.
- Uses valid/ready handshakes on both sides.
- Supports a flush that emits a zero-padded partial word tagged with its dibit count.

---
 rtl/dibit_packer.sv | 140 ++++++++++++++
 tb/tb_dibit_packer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dibit_packer.sv
// rtl/dibit_packer.sv - packs a 2-bit symbol stream MSB-first into OUT_WIDTH-bit words
//
// Purpose:
//   Collects dibits from the {a,b} concat stage and forms OUT_WIDTH-bit words.
//   The first dibit received lands in the top two bits of the word.
//   A flush emits the current partial word, left-aligned with zero padding,
//   and tags it with the number of valid dibits it holds.
//   Up to two words can be buffered at once: one in the output register and
//   one complete word in the accumulator.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   in_dibit carries a symbol
//   in_ready   out  packer accepts a symbol this cycle (registered state only)
//   in_dibit   in   symbol, bit1 = a, bit0 = b
//   flush      in   request to emit the current partial word
//   out_valid  out  out_data/out_count hold a word
//   out_ready  in   consumer takes the word this cycle
//   out_data   out  packed word, first dibit in [OUT_WIDTH-1:OUT_WIDTH-2]
//   out_count  out  valid dibits in out_data, 1..N

module dibit_packer #(
  parameter int OUT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       in_dibit,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_WIDTH-1:0]             out_data,
  output logic [$clog2(OUT_WIDTH/2):0]     out_count
);

  localparam int N  = OUT_WIDTH / 2;
  localparam int CW = $clog2(N) + 1;

  localparam logic [CW-1:0] N_CW   = CW'(N);
  localparam logic [CW-1:0] ONE_CW = CW'(1);

  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]        out_count_q, out_count_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept;
  logic                 slot_free;
  logic                 flush_req;
  logic [OUT_WIDTH-1:0] acc_nxt;
  logic [CW-1:0]        cnt_nxt;
  logic [CW:0]          pad_shamt;
  logic [OUT_WIDTH-1:0] partial_word;

  // Ready depends only on registered state, so out_ready never reaches
  // in_ready combinationally.
  assign in_ready  = (cnt_q != N_CW) && !flush_pend_q;
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid_q || out_ready;
  // A pending flush keeps asking every cycle until the slot frees up.
  assign flush_req = flush || flush_pend_q;

  // Accumulator and count as they stand after this cycle's accept, so a
  // same-cycle flush includes the dibit accepted alongside it.
  assign acc_nxt = accept ? {acc_q[OUT_WIDTH-3:0], in_dibit} : acc_q;
  assign cnt_nxt = accept ? (cnt_q + ONE_CW) : cnt_q;

  // Left-align a partial word: shift by two bits per missing dibit. The
  // shift also drops any older bits still sitting above the live dibits.
  assign pad_shamt    = {N_CW - cnt_nxt, 1'b0};
  assign partial_word = acc_nxt << pad_shamt;

  always_comb begin
    acc_d        = acc_nxt;
    cnt_d        = cnt_nxt;
    flush_pend_d = flush_pend_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_valid_d  = out_valid_q;

    // A transfer empties the output register unless a word reloads it below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (cnt_nxt == N_CW) begin
      // Full word, either just completed or held from earlier. Any flush
      // this cycle is absorbed by the full word.
      flush_pend_d = 1'b0;
      if (slot_free) begin
        out_data_d  = acc_nxt;
        out_count_d = N_CW;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end
    end else if (flush_req && (cnt_nxt != '0)) begin
      if (slot_free) begin
        out_data_d   = partial_word;
        out_count_d  = cnt_nxt;
        out_valid_d  = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
        flush_pend_d = 1'b0;
      end else begin
        // Freeze input until the partial word can move out.
        flush_pend_d = 1'b1;
      end
    end else begin
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dibit_packer.sv
// tb/tb_dibit_packer.sv - directed self-checking bench for dibit_packer

module tb_dibit_packer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_dibit;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_count;

  int checks;
  int errors;

  dibit_packer #(.OUT_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dibit  (in_dibit),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle, so sampling is away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one dibit for one cycle; the packer must be ready for it.
  task automatic send(input logic [1:0] d, input string tag);
    in_valid = 1'b1;
    in_dibit = d;
    chk(tag, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_dibit = 2'b00;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [2:0] c);
    chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
    if (v) begin
      chk({tag, "_data"},  {24'b0, out_data},  {24'b0, d});
      chk({tag, "_count"}, {29'b0, out_count}, {29'b0, c});
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_dibit  = 2'b00;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data",  {24'b0, out_data},  32'h00);
    chk("rst_count", {29'b0, out_count}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Full word, no backpressure: 10 01 11 00 -> 0x9C.
    out_ready = 1'b1;
    send(2'b10, "w1_rdy0");
    send(2'b01, "w1_rdy1");
    send(2'b11, "w1_rdy2");
    chk_out("w1_pre", 1'b0, 8'h00, 3'd0);
    send(2'b00, "w1_rdy3");
    chk_out("w1", 1'b1, 8'h9C, 3'd4);
    tick();
    chk_out("w1_drain", 1'b0, 8'h00, 3'd0);

    // Partial flush: 11 01 10 + flush -> 0xD8 count 3, then empty flush.
    send(2'b11, "f1_rdy0");
    send(2'b01, "f1_rdy1");
    send(2'b10, "f1_rdy2");
    chk_out("f1_pre", 1'b0, 8'h00, 3'd0);
    flush = 1'b1;
    tick();
    chk_out("f1", 1'b1, 8'hD8, 3'd3);
    tick();
    flush = 1'b0;
    chk_out("f1_empty", 1'b0, 8'h00, 3'd0);
    tick();
    chk_out("f1_idle", 1'b0, 8'h00, 3'd0);

    // Backpressure: two words queued, drained in order.
    out_ready = 1'b0;
    send(2'b00, "bp_rdy0");
    send(2'b01, "bp_rdy1");
    send(2'b10, "bp_rdy2");
    send(2'b11, "bp_rdy3");
    chk_out("bp_w0", 1'b1, 8'h1B, 3'd4);
    send(2'b11, "bp_rdy4");
    send(2'b10, "bp_rdy5");
    send(2'b01, "bp_rdy6");
    send(2'b00, "bp_rdy7");
    chk("bp_in_ready_lo", {31'b0, in_ready}, 32'd0);
    chk_out("bp_hold0", 1'b1, 8'h1B, 3'd4);
    tick();
    chk_out("bp_hold1", 1'b1, 8'h1B, 3'd4);
    chk("bp_in_ready_still_lo", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk_out("bp_w1", 1'b1, 8'hE4, 3'd4);
    chk("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
    tick();
    chk_out("bp_drain", 1'b0, 8'h00, 3'd0);

    // Flush against a busy slot.
    out_ready = 1'b0;
    send(2'b11, "fb_rdy0");
    send(2'b11, "fb_rdy1");
    send(2'b11, "fb_rdy2");
    send(2'b11, "fb_rdy3");
    chk_out("fb_full", 1'b1, 8'hFF, 3'd4);
    send(2'b01, "fb_rdy4");
    send(2'b01, "fb_rdy5");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fb_in_ready_pend", {31'b0, in_ready}, 32'd0);
    chk_out("fb_hold", 1'b1, 8'hFF, 3'd4);
    tick();
    chk("fb_in_ready_pend2", {31'b0, in_ready}, 32'd0);
    chk_out("fb_hold2", 1'b1, 8'hFF, 3'd4);
    out_ready = 1'b1;
    tick();
    chk_out("fb_part", 1'b1, 8'h50, 3'd2);
    chk("fb_in_ready_back", {31'b0, in_ready}, 32'd1);
    tick();
    chk_out("fb_drain", 1'b0, 8'h00, 3'd0);

    // Reset mid-word discards the partial word.
    send(2'b11, "mr_rdy0");
    send(2'b11, "mr_rdy1");
    reset = 1'b0;
    #1;
    chk_out("mr_async", 1'b0, 8'h00, 3'd0);
    tick();
    reset = 1'b1;
    tick();
    chk_out("mr_after", 1'b0, 8'h00, 3'd0);
    send(2'b01, "mr_rdy2");
    send(2'b10, "mr_rdy3");
    send(2'b01, "mr_rdy4");
    chk_out("mr_pre", 1'b0, 8'h00, 3'd0);
    send(2'b10, "mr_rdy5");
    chk_out("mr_word", 1'b1, 8'h66, 3'd4);
    tick();
    chk_out("mr_drain", 1'b0, 8'h00, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
